// File: rtl/life_engine_param.sv
// Parametrised Game-of-Life generation engine with ping-pong boards.
// Ports:
//   clk        pixel clock
//   rst_n      async active-low reset
//   step       one-cycle new-generation request
//   run        1: accept every step; 0: paused
//   single     when paused, a step is accepted only while single=1
//   reload     synchronous SEED reload into the front board; highest priority
//   rd_x/rd_y  display read coordinate
//   rd_cell    registered front-board cell at (rd_x, rd_y)
//   busy       high while a generation is being evaluated
//   done       one-cycle pulse on the cycle after the board swap
//   gen_count  completed generations since reset/reload (wraps)
module life_engine_param #(
  parameter int unsigned BIT_W = 3,
  parameter int unsigned BIT_H = 3,
  parameter int unsigned WRAP  = 0,
  parameter logic [(2**BIT_W)*(2**BIT_H)-1:0] SEED = 64'h50A8_8888_0609_0909,
  parameter int unsigned GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             run,
  input  logic             single,
  input  logic             reload,
  input  logic [BIT_W-1:0] rd_x,
  input  logic [BIT_H-1:0] rd_y,
  output logic             rd_cell,
  output logic             busy,
  output logic             done,
  output logic [GEN_W-1:0] gen_count
);

  localparam int unsigned W     = 2**BIT_W;
  localparam int unsigned H     = 2**BIT_H;
  localparam int unsigned SIZE  = W * H;
  localparam int unsigned IDX_W = BIT_W + BIT_H;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EVAL = 1'b1
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [SIZE-1:0]    r_board_a;
  logic [SIZE-1:0]    r_board_b;
  logic               r_front_b;
  logic               r_rd_cell;
  logic               r_busy;
  logic               r_done;
  logic [GEN_W-1:0]   r_gen;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [GEN_W-1:0]   w_gen_nxt;
  logic               w_front_b_nxt;
  logic               w_wr_en;

  logic [SIZE-1:0]    w_front;
  logic [BIT_W-1:0]   w_x;
  logic [BIT_H-1:0]   w_y;
  logic [3:0]         w_ncount;
  logic               w_cur;
  logic               w_new_cell;
  logic [IDX_W-1:0]   w_rd_idx;

  assign w_front    = r_front_b ? r_board_b : r_board_a;
  assign w_x        = r_idx[BIT_W-1:0];
  assign w_y        = r_idx[IDX_W-1:BIT_W];
  assign w_cur      = w_front[r_idx];
  assign w_new_cell = (w_ncount == 4'd3) | (w_cur & (w_ncount == 4'd2));
  assign w_rd_idx   = {rd_y, rd_x};

  // Live-neighbour count of the current cell in the front board.
  always_comb begin : nbr_count
    int               nx;
    int               ny;
    logic             in_b;
    logic [IDX_W-1:0] ni;
    w_ncount = 4'd0;
    nx       = 0;
    ny       = 0;
    in_b     = 1'b0;
    ni       = '0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(w_x) + dx;
        ny = int'(w_y) + dy;
        if (WRAP != 0) begin
          // Toroidal: wrap by masking to the board width/height.
          nx   = nx & (int'(W) - 1);
          ny   = ny & (int'(H) - 1);
          in_b = 1'b1;
        end else begin
          in_b = (nx >= 0) && (nx < int'(W)) && (ny >= 0) && (ny < int'(H));
        end
        if (dx == 0 && dy == 0) in_b = 1'b0;
        ni = IDX_W'(ny * int'(W) + nx);
        if (in_b) w_ncount = w_ncount + {3'b000, w_front[ni]};
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_gen_nxt     = r_gen;
    w_front_b_nxt = r_front_b;
    w_wr_en       = 1'b0;
    if (reload) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_busy_nxt  = 1'b0;
      w_gen_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (step && (run || single)) begin
            w_state_nxt = S_EVAL;
            w_idx_nxt   = '0;
            w_busy_nxt  = 1'b1;
          end
        end
        S_EVAL: begin
          w_wr_en   = 1'b1;
          w_idx_nxt = r_idx + IDX_W'(1);
          if (r_idx == IDX_W'(SIZE - 1)) begin
            w_state_nxt   = S_IDLE;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
            w_gen_nxt     = r_gen + GEN_W'(1);
            w_front_b_nxt = ~r_front_b;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_gen     <= '0;
      r_front_b <= 1'b0;
      r_rd_cell <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_gen     <= w_gen_nxt;
      r_front_b <= w_front_b_nxt;
      r_rd_cell <= w_front[w_rd_idx];
    end
  end

  // Board storage: reload overwrites the front; evaluation writes the back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_board_a <= SEED;
      r_board_b <= '0;
    end else if (reload) begin
      if (r_front_b) r_board_b <= SEED;
      else           r_board_a <= SEED;
    end else if (w_wr_en) begin
      if (r_front_b) r_board_a[r_idx] <= w_new_cell;
      else           r_board_b[r_idx] <= w_new_cell;
    end
  end

  assign rd_cell   = r_rd_cell;
  assign busy      = r_busy;
  assign done      = r_done;
  assign gen_count = r_gen;

endmodule
